z2_bus_sm: RTL and testbench

- Zorro II slave bus-cycle sequencer. It sits directly upstream of the autoconfig/address-decode block.
- Synchronises the asynchronous 68000 strobes (AS_n, UDS_n, LDS_n) to CLK and produces the z2_state phase code that the decoder uses to qualify its autoconfig register accesses.
- Merges the decoder's one-cycle autoconfig dtack pulse with locally timed wait states for RAM, IDE, control and flash hits. Drives the board DTACK_n and data-bus enables.

---
 rtl/z2_bus_sm.sv | 187 ++++++++++++++++++
 tb/tb_z2_bus_sm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z2_bus_sm.sv
// Zorro II slave bus-cycle sequencer: synchronises the 68000 strobes, tracks the
// bus phase for the autoconfig decoder and times DTACK / data-bus enables per access class.
`timescale 1ns/1ps
module z2_bus_sm #(
  parameter int RAM_WAIT   = 0,
  parameter int IO_WAIT    = 2,
  parameter int AC_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       autoconfig_cycle,
  input  logic       ram_access,
  input  logic       flash_access,
  input  logic       ide_access,
  input  logic       ctrl_access,
  input  logic       ac_dtack,
  output logic [1:0] z2_state,
  output logic       DTACK_n,
  output logic       dtack_oe,
  output logic       data_oe,
  output logic       wr_strobe
);

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'b00,
    Z2_START = 2'b01,
    Z2_DATA  = 2'b10,
    Z2_END   = 2'b11
  } z2_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_AC,
    CLS_MEM,
    CLS_IO
  } cls_t;

  localparam logic [3:0] RAM_LAST = 4'(RAM_WAIT);
  localparam logic [3:0] IO_LAST  = 4'(IO_WAIT);
  localparam logic [3:0] AC_LAST  = 4'(AC_TIMEOUT - 1);

  z2_state_t  state;
  cls_t       cls;
  cls_t       start_cls;
  logic [3:0] cnt;
  logic [1:0] as_sync;
  logic [1:0] uds_sync;
  logic [1:0] lds_sync;
  logic [1:0] sync_vld;
  logic       armed;
  logic       as;
  logic       ds;
  logic       hit;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sync  <= '1;
      uds_sync <= '1;
      lds_sync <= '1;
    end else begin
      as_sync  <= {as_sync[0], AS_n};
      uds_sync <= {uds_sync[0], UDS_n};
      lds_sync <= {lds_sync[0], LDS_n};
    end
  end

  assign as = ~as_sync[1];
  assign ds = ~uds_sync[1] | ~lds_sync[1];

  always_comb begin
    start_cls = CLS_NONE;
    if (autoconfig_cycle)
      start_cls = CLS_AC;
    else if (ide_access | ctrl_access)
      start_cls = CLS_IO;
    else if (ram_access | flash_access)
      start_cls = CLS_MEM;
  end

  assign hit      = (start_cls != CLS_NONE);
  assign z2_state = state;

  // armed only goes high once the synchroniser holds real samples and shows AS
  // negated, so a strobe still low across reset cannot start a cycle.
  // data_oe doubles as the latched RW for the cycle in progress.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= Z2_IDLE;
      cls       <= CLS_NONE;
      cnt       <= '0;
      sync_vld  <= '0;
      armed     <= 1'b0;
      DTACK_n   <= 1'b1;
      dtack_oe  <= 1'b0;
      data_oe   <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      sync_vld  <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !as)
        armed <= 1'b1;

      case (state)
        Z2_IDLE: begin
          DTACK_n  <= 1'b1;
          dtack_oe <= 1'b0;
          data_oe  <= 1'b0;
          cls      <= CLS_NONE;
          if (as && armed)
            state <= Z2_START;
        end

        Z2_START: begin
          if (!as) begin
            state <= Z2_IDLE;
          end else if (!hit) begin
            state <= Z2_END;
          end else if (ds) begin
            state     <= Z2_DATA;
            cls       <= start_cls;
            cnt       <= '0;
            wr_strobe <= ~RW;
            data_oe   <= RW;
          end
        end

        Z2_DATA: begin
          if (!as) begin
            state    <= Z2_IDLE;
            DTACK_n  <= 1'b1;
            dtack_oe <= 1'b0;
            data_oe  <= 1'b0;
          end else begin
            case (cls)
              CLS_AC: begin
                if (ac_dtack) begin
                  state    <= Z2_END;
                  DTACK_n  <= 1'b0;
                  dtack_oe <= 1'b1;
                end else if (cnt == AC_LAST) begin
                  state <= Z2_END;
                end else begin
                  cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                end
              end
              CLS_MEM: begin
                if (cnt == RAM_LAST) begin
                  state    <= Z2_END;
                  DTACK_n  <= 1'b0;
                  dtack_oe <= 1'b1;
                end else begin
                  cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                end
              end
              CLS_IO: begin
                if (cnt == IO_LAST) begin
                  state    <= Z2_END;
                  DTACK_n  <= 1'b0;
                  dtack_oe <= 1'b1;
                end else begin
                  cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                end
              end
              default: state <= Z2_END;
            endcase
          end
        end

        Z2_END: begin
          // DTACK_n goes high here; dtack_oe follows from IDLE one cycle later.
          if (!as) begin
            state   <= Z2_IDLE;
            DTACK_n <= 1'b1;
            data_oe <= 1'b0;
          end
        end

        default: state <= Z2_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z2_bus_sm.sv
// Directed bench for z2_bus_sm: drives 68000 strobe sequences and compares the
// bus phase, DTACK and enable outputs against hand-derived cycle-by-cycle values.
`timescale 1ns/1ps
module tb_z2_bus_sm;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b1;
  logic       AS_n, UDS_n, LDS_n, RW;
  logic       autoconfig_cycle, ram_access, flash_access, ide_access, ctrl_access, ac_dtack;
  logic [1:0] z2_state;
  logic       DTACK_n, dtack_oe, data_oe, wr_strobe;

  int vec = 0;
  int err = 0;

  always #5 CLK = ~CLK;

  z2_bus_sm #(.RAM_WAIT(0), .IO_WAIT(2), .AC_TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
    .autoconfig_cycle(autoconfig_cycle), .ram_access(ram_access), .flash_access(flash_access),
    .ide_access(ide_access), .ctrl_access(ctrl_access), .ac_dtack(ac_dtack),
    .z2_state(z2_state), .DTACK_n(DTACK_n), .dtack_oe(dtack_oe), .data_oe(data_oe),
    .wr_strobe(wr_strobe)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_idle;
    AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    autoconfig_cycle = 1'b0; ram_access = 1'b0; flash_access = 1'b0;
    ide_access = 1'b0; ctrl_access = 1'b0; ac_dtack = 1'b0;
  endtask

  task automatic end_cycle;
    bus_idle();
    tick(4);
  endtask

  task automatic test_reset;
    bus_idle();
    #1 RESET_n = 1'b0;
    #3;
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL rst_state got=%b exp=00", z2_state); end
    vec++; if (DTACK_n !== 1'b1) begin err++; $display("FAIL rst_dtack got=%b exp=1", DTACK_n); end
    vec++; if (dtack_oe !== 1'b0) begin err++; $display("FAIL rst_dtack_oe got=%b exp=0", dtack_oe); end
    vec++; if (data_oe !== 1'b0) begin err++; $display("FAIL rst_data_oe got=%b exp=0", data_oe); end
    vec++; if (wr_strobe !== 1'b0) begin err++; $display("FAIL rst_wr_strobe got=%b exp=0", wr_strobe); end
    tick(2);
    RESET_n = 1'b1;
    tick(4);
  endtask

  task automatic test_ac_read;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; autoconfig_cycle = 1'b1;
    tick(2);
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL ac_sync got=%b exp=00", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL ac_start got=%b exp=01", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL ac_data0 got=%b exp=10", z2_state); end
    vec++; if (data_oe !== 1'b1) begin err++; $display("FAIL ac_data_oe got=%b exp=1", data_oe); end
    vec++; if (wr_strobe !== 1'b0) begin err++; $display("FAIL ac_no_wr got=%b exp=0", wr_strobe); end
    tick(1);
    vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL ac_data1 got=%b exp=10", z2_state); end
    vec++; if (DTACK_n !== 1'b1) begin err++; $display("FAIL ac_data1_dtack got=%b exp=1", DTACK_n); end
    ac_dtack = 1'b1;
    tick(1);
    ac_dtack = 1'b0;
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL ac_end got=%b exp=11", z2_state); end
    vec++; if (DTACK_n !== 1'b0) begin err++; $display("FAIL ac_end_dtack got=%b exp=0", DTACK_n); end
    vec++; if (dtack_oe !== 1'b1) begin err++; $display("FAIL ac_end_dtack_oe got=%b exp=1", dtack_oe); end
    vec++; if (data_oe !== 1'b1) begin err++; $display("FAIL ac_end_data_oe got=%b exp=1", data_oe); end
    tick(1);
    vec++; if (DTACK_n !== 1'b0) begin err++; $display("FAIL ac_end_hold got=%b exp=0", DTACK_n); end
    AS_n = 1'b1; UDS_n = 1'b1; autoconfig_cycle = 1'b0;
    tick(2);
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL ac_end_sync got=%b exp=11", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL ac_idle got=%b exp=00", z2_state); end
    vec++; if (DTACK_n !== 1'b1) begin err++; $display("FAIL ac_idle_dtack got=%b exp=1", DTACK_n); end
    vec++; if (dtack_oe !== 1'b1) begin err++; $display("FAIL ac_idle_oe_held got=%b exp=1", dtack_oe); end
    vec++; if (data_oe !== 1'b0) begin err++; $display("FAIL ac_idle_data_oe got=%b exp=0", data_oe); end
    tick(1);
    vec++; if (dtack_oe !== 1'b0) begin err++; $display("FAIL ac_idle_oe_off got=%b exp=0", dtack_oe); end
  endtask

  task automatic test_ram_write;
    AS_n = 1'b0; RW = 1'b0; ram_access = 1'b1;
    tick(3);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL ramw_start got=%b exp=01", z2_state); end
    LDS_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      vec++; if (z2_state !== 2'b01 || wr_strobe !== 1'b0) begin
        err++; $display("FAIL ramw_wait%0d got=%b/%b exp=01/0", i, z2_state, wr_strobe);
      end
    end
    tick(1);
    vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL ramw_data got=%b exp=10", z2_state); end
    vec++; if (wr_strobe !== 1'b1) begin err++; $display("FAIL ramw_strobe got=%b exp=1", wr_strobe); end
    vec++; if (data_oe !== 1'b0) begin err++; $display("FAIL ramw_data_oe got=%b exp=0", data_oe); end
    tick(1);
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL ramw_end got=%b exp=11", z2_state); end
    vec++; if (DTACK_n !== 1'b0 || dtack_oe !== 1'b1) begin
      err++; $display("FAIL ramw_dtack got=%b/%b exp=0/1", DTACK_n, dtack_oe);
    end
    vec++; if (wr_strobe !== 1'b0) begin err++; $display("FAIL ramw_strobe_once got=%b exp=0", wr_strobe); end
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vec++; if (wr_strobe !== 1'b0 || data_oe !== 1'b0) begin
        err++; $display("FAIL ramw_release%0d got=%b/%b exp=0/0", i, wr_strobe, data_oe);
      end
    end
  endtask

  task automatic test_ide_read;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; ide_access = 1'b1;
    tick(3);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL ide_start got=%b exp=01", z2_state); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vec++; if (z2_state !== 2'b10 || DTACK_n !== 1'b1 || data_oe !== 1'b1) begin
        err++; $display("FAIL ide_data%0d got=%b/%b/%b exp=10/1/1", i, z2_state, DTACK_n, data_oe);
      end
    end
    tick(1);
    vec++; if (z2_state !== 2'b11 || DTACK_n !== 1'b0 || dtack_oe !== 1'b1) begin
      err++; $display("FAIL ide_end got=%b/%b/%b exp=11/0/1", z2_state, DTACK_n, dtack_oe);
    end
    end_cycle();
  endtask

  task automatic test_miss;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b0;
    tick(3);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL miss_start got=%b exp=01", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL miss_end got=%b exp=11", z2_state); end
    vec++; if (DTACK_n !== 1'b1 || dtack_oe !== 1'b0) begin
      err++; $display("FAIL miss_dtack got=%b/%b exp=1/0", DTACK_n, dtack_oe);
    end
    vec++; if (wr_strobe !== 1'b0 || data_oe !== 1'b0) begin
      err++; $display("FAIL miss_enables got=%b/%b exp=0/0", wr_strobe, data_oe);
    end
    ac_dtack = 1'b1;
    tick(1);
    ac_dtack = 1'b0;
    vec++; if (DTACK_n !== 1'b1 || z2_state !== 2'b11) begin
      err++; $display("FAIL miss_stray_ack got=%b/%b exp=1/11", DTACK_n, z2_state);
    end
    bus_idle();
    tick(3);
    vec++; if (z2_state !== 2'b00 || DTACK_n !== 1'b1 || dtack_oe !== 1'b0) begin
      err++; $display("FAIL miss_idle got=%b/%b/%b exp=00/1/0", z2_state, DTACK_n, dtack_oe);
    end
    tick(1);
  endtask

  task automatic test_abort;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; ctrl_access = 1'b1;
    tick(3);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL abort_start got=%b exp=01", z2_state); end
    AS_n = 1'b1;
    tick(1);
    vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL abort_data0 got=%b exp=10", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL abort_data1 got=%b exp=10", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL abort_idle got=%b exp=00", z2_state); end
    vec++; if (DTACK_n !== 1'b1 || dtack_oe !== 1'b0 || data_oe !== 1'b0) begin
      err++; $display("FAIL abort_outs got=%b/%b/%b exp=1/0/0", DTACK_n, dtack_oe, data_oe);
    end
    end_cycle();
  endtask

  task automatic test_ac_timeout;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; autoconfig_cycle = 1'b1;
    tick(3);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL to_start got=%b exp=01", z2_state); end
    for (int i = 0; i < 15; i++) begin
      tick(1);
      vec++; if (z2_state !== 2'b10) begin err++; $display("FAIL to_data%0d got=%b exp=10", i, z2_state); end
    end
    tick(1);
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL to_end got=%b exp=11", z2_state); end
    vec++; if (DTACK_n !== 1'b1 || dtack_oe !== 1'b0) begin
      err++; $display("FAIL to_dtack got=%b/%b exp=1/0", DTACK_n, dtack_oe);
    end
    vec++; if (data_oe !== 1'b1) begin err++; $display("FAIL to_data_oe got=%b exp=1", data_oe); end
    end_cycle();
  endtask

  task automatic test_back_to_back;
    AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0; ram_access = 1'b1;
    tick(5);
    vec++; if (z2_state !== 2'b11 || DTACK_n !== 1'b0) begin
      err++; $display("FAIL b2b_end got=%b/%b exp=11/0", z2_state, DTACK_n);
    end
    AS_n = 1'b1;
    tick(1);
    AS_n = 1'b0;
    tick(1);
    vec++; if (z2_state !== 2'b11) begin err++; $display("FAIL b2b_hold got=%b exp=11", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b00 || DTACK_n !== 1'b1 || dtack_oe !== 1'b1) begin
      err++; $display("FAIL b2b_idle got=%b/%b/%b exp=00/1/1", z2_state, DTACK_n, dtack_oe);
    end
    tick(1);
    vec++; if (z2_state !== 2'b01 || dtack_oe !== 1'b0) begin
      err++; $display("FAIL b2b_restart got=%b/%b exp=01/0", z2_state, dtack_oe);
    end
    tick(1);
    vec++; if (z2_state !== 2'b10 || wr_strobe !== 1'b1) begin
      err++; $display("FAIL b2b_data got=%b/%b exp=10/1", z2_state, wr_strobe);
    end
    tick(1);
    vec++; if (z2_state !== 2'b11 || DTACK_n !== 1'b0) begin
      err++; $display("FAIL b2b_end2 got=%b/%b exp=11/0", z2_state, DTACK_n);
    end
    end_cycle();
  endtask

  task automatic test_reset_mid;
    AS_n = 1'b0; UDS_n = 1'b0; RW = 1'b1; ram_access = 1'b1;
    tick(5);
    vec++; if (z2_state !== 2'b11 || DTACK_n !== 1'b0 || data_oe !== 1'b1) begin
      err++; $display("FAIL rmid_pre got=%b/%b/%b exp=11/0/1", z2_state, DTACK_n, data_oe);
    end
    #2 RESET_n = 1'b0;
    #1;
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL rmid_state got=%b exp=00", z2_state); end
    vec++; if (DTACK_n !== 1'b1 || dtack_oe !== 1'b0 || data_oe !== 1'b0) begin
      err++; $display("FAIL rmid_outs got=%b/%b/%b exp=1/0/0", DTACK_n, dtack_oe, data_oe);
    end
    tick(2);
    RESET_n = 1'b1;
    tick(6);
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL rmid_held_low got=%b exp=00", z2_state); end
    AS_n = 1'b1;
    tick(4);
    AS_n = 1'b0;
    tick(2);
    vec++; if (z2_state !== 2'b00) begin err++; $display("FAIL rmid_sync got=%b exp=00", z2_state); end
    tick(1);
    vec++; if (z2_state !== 2'b01) begin err++; $display("FAIL rmid_restart got=%b exp=01", z2_state); end
    end_cycle();
  endtask

  initial begin
    test_reset();
    test_ac_read();
    test_ram_write();
    test_ide_read();
    test_miss();
    test_abort();
    test_ac_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
